regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-side front end for the 32x32 CPU register file. Merges write-back requests from two producers into the register file's single write port. The producers are the single-cycle ALU path and the long-latency load/multiply/divide path. Also keeps a per-register pending-write scoreboard that the decode stage uses for hazard stalls. Sits between the execute/memory stages and the register file; its outputs drive the register file's `we`/`waddr`/`wdata` directly.

## Interface
- `NUM_SRC`, default 2: number of write-back sources; fixed at 2 in this revision.
- `clk` input 1: system clock; all state updates on rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `s0_valid` input 1: ALU-path write request.
- `s0_addr` input 5: destination register.
- `s0_data` input 32: write value.
- `s0_ready` output 1: request accepted this cycle.
- `s1_valid` input 1: long-latency-path write request.
- `s1_addr` input 5: destination register.
- `s1_data` input 32: write value.
- `s1_ready` output 1: request accepted this cycle.
- `rsv_valid` input 1: decode reserves a destination register.
- `rsv_addr` input 5: register being reserved.
- `chk_addr1` input 5: decode source-operand lookup 1.
- `chk_addr2` input 5: decode source-operand lookup 2.
- `chk_busy1` output 1: combinational; register `chk_addr1` has a pending write.
- `chk_busy2` output 1: combinational; register `chk_addr2` has a pending write.
- `we` output 1: register-file write enable.
- `waddr` output 5: register-file write address.
- `wdata` output 32: register-file write data.

## Operation
- Handshake: a transfer occurs when `sX_valid & sX_ready` at a rising edge. Producers hold addr/data stable while valid and not ready.
- Arbitration is two-way round-robin:
  - One requester only: it is granted.
  - Both requesting: the source not granted last time wins.
  - After reset, s0 has priority.
- `sX_ready` is combinational from the valid inputs and the priority pointer. The output stage drains every cycle, so there is no back-pressure beyond arbitration loss.
- An accepted request loads the output register: `we`=1, `waddr`, `wdata`.
- A request to address 0 is accepted but produces `we`=0 and leaves the scoreboard untouched.
- Scoreboard: a 32-bit busy vector.
  - `rsv_valid` sets `busy[rsv_addr]`; address 0 is ignored.
  - A retiring write (output stage with `we`=1) clears `busy[waddr]`.
  - Reserve and retire on the same address in the same cycle: the reserve wins and the bit stays 1.
  - Reserving an already-busy register is a protocol violation. Decode stalls on WAW; the bench flags it.
- `chk_busy1` and `chk_busy2` read the busy vector; address 0 always reports 0.
- Reset (asynchronous, any time):
  - `we`=0, `waddr`=0, `wdata`=0.
  - Busy vector cleared.
  - Priority pointer set to s0.
  - A request in flight is lost; producers re-issue after reset.

## Timing
- Accept at edge N: `we`/`waddr`/`wdata` are valid for the whole cycle N..N+1. The register file commits on the falling edge inside that cycle.
- The busy bit clears at edge N+1. `chk_busy` is low from cycle N+1..N+2 on, when register-file read data is already updated.
- Accept-to-visible latency: 1 cycle.
- Sustained throughput: one write per cycle. With both sources saturated, each source gets 50%, strictly alternating.

## Configuration
- `REGFILE_WB_BYPASS_EN` defined:
  - Adds outputs `fwd_hit1`, `fwd_hit2` (1 bit) and `fwd_data` (32 bits).
  - `fwd_hitK`=1 when the output stage has `we`=1 and `waddr`==`chk_addrK`≠0.
  - `fwd_data`=`wdata`.
  - `chk_busyK` is then suppressed to 0 for that address in that cycle.
- `REGFILE_WB_BYPASS_EN` undefined: ports absent, no forwarding, `chk_busy` unaffected.

## Structure
- Package `regfile_wb_pkg`:
  - `REG_ADDR_W`=5, `DATA_W`=32, `NUM_REGS`=32.
  - Source-id enum `SRC_ALU`/`SRC_LONG`.
  - Packed write-request struct {addr, data}.
- Sub-module `rr_arbiter2`: two request inputs, two one-hot grant outputs, internal last-grant flop, update enable. Instantiated once.
- Everything else (output register, scoreboard, bypass compare) lives in the top module.

## Test plan
- Reset, then s0 writes addr 5 data 0xDEADBEEF → next cycle `we`=1, `waddr`=5, `wdata`=0xDEADBEEF; a subsequent read of r5 returns 0xDEADBEEF.
- s0 and s1 valid for 4 cycles with distinct addrs 1..8 → grants alternate s0,s1,s0,s1; after reset the first grant is s0; all 4 accepted writes appear in order.
- Reserve r7, then s1 writes r7 three cycles later → `chk_busy1`(r7)=1 from the cycle after the reserve until edge N+1 after acceptance, then 0.
- Write to addr 0 with data 0x1234 → accepted (`s0_ready`=1), `we`=0, r0 still reads 0, `chk_busy` for addr 0 always 0.
- Reserve r3 in the same cycle an earlier r3 write retires → busy[3] remains 1.
- Assert `rst` low mid-transfer with busy bits 2,9 set → `we`=0 immediately, all busy 0, next conflicting request is granted to s0. With `REGFILE_WB_BYPASS_EN`, a write to r4 in the output stage plus `chk_addr1`=4 → `fwd_hit1`=1, `fwd_data`=`wdata`.

Source files
------------

// File: rtl/regfile_wb_pkg.sv
// Shared widths, source ids and the write-request record for the register-file write-back front end.
package regfile_wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  typedef enum logic {
    SRC_ALU  = 1'b0,
    SRC_LONG = 1'b1
  } src_id_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wr_req_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] a);
    return {{(NUM_REGS-1){1'b0}}, 1'b1} << a;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the priority pointer names the source that wins a tie.
module rr_arbiter2
  import regfile_wb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] grant_o
);

  src_id_e prio_q, prio_d;

  always_comb begin
    grant_o = 2'b00;
    prio_d  = prio_q;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = (prio_q == SRC_ALU) ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
    // Priority passes to whichever source was not just served.
    if (update_i && (grant_o != 2'b00))
      prio_d = grant_o[0] ? SRC_LONG : SRC_ALU;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prio_q <= SRC_ALU;
    else      prio_q <= prio_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter with pending-write scoreboard.
// Optional forwarding outputs are enabled by defining REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int NUM_SRC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s0_valid,
  input  logic [REG_ADDR_W-1:0] s0_addr,
  input  logic [DATA_W-1:0]     s0_data,
  output logic                  s0_ready,
  input  logic                  s1_valid,
  input  logic [REG_ADDR_W-1:0] s1_addr,
  input  logic [DATA_W-1:0]     s1_data,
  output logic                  s1_ready,
  input  logic                  rsv_valid,
  input  logic [REG_ADDR_W-1:0] rsv_addr,
  input  logic [REG_ADDR_W-1:0] chk_addr1,
  input  logic [REG_ADDR_W-1:0] chk_addr2,
  output logic                  chk_busy1,
  output logic                  chk_busy2,
  output logic                  we,
  output logic [REG_ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0]     wdata
`ifdef REGFILE_WB_BYPASS_EN
  ,
  output logic                  fwd_hit1,
  output logic                  fwd_hit2,
  output logic [DATA_W-1:0]     fwd_data
`endif
);

  logic [NUM_SRC-1:0] req, grant;
  wr_req_t            src_req [NUM_SRC];
  wr_req_t            sel_req;
  logic               accept;

  logic                  we_q, we_d;
  logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;

  assign req        = {s1_valid, s0_valid};
  assign src_req[0] = {s0_addr, s0_data};
  assign src_req[1] = {s1_addr, s1_data};

  // The output stage drains every cycle, so the pointer advances on every grant.
  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req),
    .update_i (1'b1),
    .grant_o  (grant)
  );

  assign s0_ready = grant[0];
  assign s1_ready = grant[1];
  assign accept   = |grant;
  assign sel_req  = grant[1] ? src_req[1] : src_req[0];

  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (accept) begin
      we_d    = (sel_req.addr != '0);
      waddr_d = sel_req.addr;
      wdata_d = sel_req.data;
    end
    // Set after clear so a same-cycle reserve beats the retiring write.
    busy_d = busy_q;
    if (we_q)
      busy_d = busy_d & ~reg_onehot(waddr_q);
    if (rsv_valid && (rsv_addr != '0))
      busy_d = busy_d | reg_onehot(rsv_addr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  logic [REG_ADDR_W-1:0] chk_addr [2];
  logic [1:0]            chk_busy;

  assign chk_addr[0] = chk_addr1;
  assign chk_addr[1] = chk_addr2;

`ifdef REGFILE_WB_BYPASS_EN
  logic [1:0] fwd_hit;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chk
`ifdef REGFILE_WB_BYPASS_EN
      assign fwd_hit[gi]  = we_q && (waddr_q == chk_addr[gi]) && (chk_addr[gi] != '0);
      assign chk_busy[gi] = (chk_addr[gi] != '0) && busy_q[chk_addr[gi]] && !fwd_hit[gi];
`else
      assign chk_busy[gi] = (chk_addr[gi] != '0) && busy_q[chk_addr[gi]];
`endif
    end
  endgenerate

  assign chk_busy1 = chk_busy[0];
  assign chk_busy2 = chk_busy[1];

`ifdef REGFILE_WB_BYPASS_EN
  assign fwd_hit1 = fwd_hit[0];
  assign fwd_hit2 = fwd_hit[1];
  assign fwd_data = wdata_q;
`endif

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// against a behavioural model of the write port, arbitration rule and scoreboard.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        s0_valid, s1_valid, rsv_valid;
  logic [4:0]  s0_addr, s1_addr, rsv_addr, chk_addr1, chk_addr2;
  logic [31:0] s0_data, s1_data;
  logic        s0_ready, s1_ready, chk_busy1, chk_busy2, we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
`ifdef REGFILE_WB_BYPASS_EN
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data;
`endif

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  bit          exp_busy [32];
  int          pref;
  bit          exp_we;
  logic [4:0]  exp_waddr;
  logic [31:0] exp_wdata;
  int          last_g;

  logic [31:0] rf [32];

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NUM_SRC(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .s0_valid  (s0_valid),
    .s0_addr   (s0_addr),
    .s0_data   (s0_data),
    .s0_ready  (s0_ready),
    .s1_valid  (s1_valid),
    .s1_addr   (s1_addr),
    .s1_data   (s1_data),
    .s1_ready  (s1_ready),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .chk_addr1 (chk_addr1),
    .chk_addr2 (chk_addr2),
    .chk_busy1 (chk_busy1),
    .chk_busy2 (chk_busy2),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata)
`ifdef REGFILE_WB_BYPASS_EN
    ,
    .fwd_hit1  (fwd_hit1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data  (fwd_data)
`endif
  );

  // Register file stand-in: commits on the falling edge inside the write cycle.
  always @(negedge clk) begin
    if (we) rf[waddr] <= wdata;
  end

  function automatic bit exp_chk(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
`ifdef REGFILE_WB_BYPASS_EN
    if (exp_we && exp_waddr == a) return 1'b0;
`endif
    return exp_busy[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) exp_busy[i] = 1'b0;
    pref      = 0;
    exp_we    = 1'b0;
    exp_waddr = '0;
    exp_wdata = '0;
    last_g    = -1;
  endtask

  task automatic clear_inputs();
    s0_valid = 0; s0_addr = 0; s0_data = 0;
    s1_valid = 0; s1_addr = 0; s1_data = 0;
    rsv_valid = 0; rsv_addr = 0;
    chk_addr1 = 0; chk_addr2 = 0;
  endtask

  // One clock cycle: combinational checks at the falling edge, registered checks after the rising edge.
  task automatic cycle(input string tag);
    int g;
    bit e1, e2;
    @(negedge clk);
    if (s0_valid && s1_valid) g = pref;
    else if (s0_valid)        g = 0;
    else if (s1_valid)        g = 1;
    else                      g = -1;
    tests++;
    if (s0_ready !== (g == 0)) begin
      fails++; $display("FAIL %s s0_ready: got %0b want %0b", tag, s0_ready, (g == 0));
    end
    tests++;
    if (s1_ready !== (g == 1)) begin
      fails++; $display("FAIL %s s1_ready: got %0b want %0b", tag, s1_ready, (g == 1));
    end
    e1 = exp_chk(chk_addr1);
    e2 = exp_chk(chk_addr2);
    tests++;
    if (chk_busy1 !== e1) begin
      fails++; $display("FAIL %s chk_busy1(r%0d): got %0b want %0b", tag, chk_addr1, chk_busy1, e1);
    end
    tests++;
    if (chk_busy2 !== e2) begin
      fails++; $display("FAIL %s chk_busy2(r%0d): got %0b want %0b", tag, chk_addr2, chk_busy2, e2);
    end
`ifdef REGFILE_WB_BYPASS_EN
    tests++;
    if (fwd_hit1 !== (exp_we && exp_waddr == chk_addr1 && chk_addr1 != 0)) begin
      fails++; $display("FAIL %s fwd_hit1: got %0b", tag, fwd_hit1);
    end
    tests++;
    if (fwd_hit2 !== (exp_we && exp_waddr == chk_addr2 && chk_addr2 != 0)) begin
      fails++; $display("FAIL %s fwd_hit2: got %0b", tag, fwd_hit2);
    end
    if (exp_we) begin
      tests++;
      if (fwd_data !== exp_wdata) begin
        fails++; $display("FAIL %s fwd_data: got %h want %h", tag, fwd_data, exp_wdata);
      end
    end
`endif
    @(posedge clk);
    #1;
    if (exp_we) exp_busy[exp_waddr] = 1'b0;
    if (rsv_valid && rsv_addr != 0) exp_busy[rsv_addr] = 1'b1;
    if (g >= 0) begin
      pref      = 1 - g;
      exp_we    = (g == 0) ? (s0_addr != 0) : (s1_addr != 0);
      exp_waddr = (g == 0) ? s0_addr : s1_addr;
      exp_wdata = (g == 0) ? s0_data : s1_data;
    end else begin
      exp_we = 1'b0;
    end
    last_g = g;
    tests++;
    if (we !== exp_we) begin
      fails++; $display("FAIL %s we: got %0b want %0b", tag, we, exp_we);
    end
    if (exp_we) begin
      tests++;
      if (waddr !== exp_waddr) begin
        fails++; $display("FAIL %s waddr: got %0d want %0d", tag, waddr, exp_waddr);
      end
      tests++;
      if (wdata !== exp_wdata) begin
        fails++; $display("FAIL %s wdata: got %h want %h", tag, wdata, exp_wdata);
      end
    end
    $display("[TB] %s grant=%0d we=%0b waddr=%0d wdata=%h", tag, g, we, waddr, wdata);
  endtask

  // Checks made while rst is held low: cleared outputs and an all-zero scoreboard.
  task automatic check_in_reset(input string tag);
    tests++;
    if (we !== 1'b0 || waddr !== 5'd0 || wdata !== 32'd0) begin
      fails++; $display("FAIL %s outputs: got we=%0b waddr=%0d wdata=%h want 0/0/0", tag, we, waddr, wdata);
    end
    for (int a = 0; a < 32; a++) begin
      chk_addr1 = 5'(a);
      chk_addr2 = 5'(31 - a);
      #1;
      tests++;
      if (chk_busy1 !== 1'b0 || chk_busy2 !== 1'b0) begin
        fails++; $display("FAIL %s busy r%0d/r%0d: got %0b/%0b want 0/0", tag, a, 31 - a, chk_busy1, chk_busy2);
      end
    end
    $display("[TB] %s reset state checked", tag);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    check_in_reset("reset");
    model_reset();
    release_reset();
  endtask

  task automatic test_alternate();
    int i0 = 0, i1 = 0;
    for (int k = 0; k < 4; k++) begin
      s0_valid = 1; s0_addr = 5'(1 + 2 * i0); s0_data = 32'h1000_0000 + 32'(i0);
      s1_valid = 1; s1_addr = 5'(2 + 2 * i1); s1_data = 32'h2000_0000 + 32'(i1);
      cycle("alternate");
      tests++;
      if (last_g != k % 2) begin
        fails++; $display("FAIL alternate grant%0d: got s%0d want s%0d", k, last_g, k % 2);
      end
      tests++;
      if (waddr !== 5'(k + 1)) begin
        fails++; $display("FAIL alternate order%0d: got waddr=%0d want %0d", k, waddr, k + 1);
      end
      if (last_g == 0) i0++;
      else if (last_g == 1) i1++;
    end
    clear_inputs();
    cycle("alternate_idle");
  endtask

  task automatic test_single_write();
    s0_valid = 1; s0_addr = 5'd5; s0_data = 32'hDEADBEEF;
    cycle("single");
    tests++;
    if (we !== 1'b1 || waddr !== 5'd5 || wdata !== 32'hDEADBEEF) begin
      fails++; $display("FAIL single out: got we=%0b waddr=%0d wdata=%h want 1/5/deadbeef", we, waddr, wdata);
    end
    clear_inputs();
    cycle("single_idle");
    tests++;
    if (rf[5] !== 32'hDEADBEEF) begin
      fails++; $display("FAIL single rf_read: got %h want deadbeef", rf[5]);
    end
  endtask

  task automatic test_busy();
    chk_addr1 = 5'd7;
    rsv_valid = 1; rsv_addr = 5'd7;
    cycle("busy_rsv");
    rsv_valid = 0;
    tests++;
    if (chk_busy1 !== 1'b1) begin
      fails++; $display("FAIL busy after_rsv: got %0b want 1", chk_busy1);
    end
    cycle("busy_wait");
    cycle("busy_wait");
    s1_valid = 1; s1_addr = 5'd7; s1_data = $urandom;
    cycle("busy_write");
    s1_valid = 0;
    cycle("busy_retire");
    tests++;
    if (chk_busy1 !== 1'b0) begin
      fails++; $display("FAIL busy cleared: got %0b want 0", chk_busy1);
    end
    cycle("busy_after");
    clear_inputs();
  endtask

  task automatic test_addr0();
    s0_valid = 1; s0_addr = 5'd0; s0_data = 32'h1234;
    cycle("addr0");
    tests++;
    if (we !== 1'b0) begin
      fails++; $display("FAIL addr0 we: got %0b want 0", we);
    end
    s0_valid = 0;
    rsv_valid = 1; rsv_addr = 5'd0; chk_addr1 = 5'd0;
    cycle("addr0_rsv");
    rsv_valid = 0;
    tests++;
    if (chk_busy1 !== 1'b0) begin
      fails++; $display("FAIL addr0 busy: got %0b want 0", chk_busy1);
    end
    cycle("addr0_idle");
    tests++;
    if (rf[0] !== 32'd0) begin
      fails++; $display("FAIL addr0 rf_read: got %h want 0", rf[0]);
    end
    clear_inputs();
  endtask

  task automatic test_rsv_retire();
    s0_valid = 1; s0_addr = 5'd3; s0_data = 32'hCAFE0003;
    cycle("rsvret_write");
    clear_inputs();
    rsv_valid = 1; rsv_addr = 5'd3; chk_addr1 = 5'd3;
    cycle("rsvret_same");
    rsv_valid = 0;
    tests++;
    if (chk_busy1 !== 1'b1) begin
      fails++; $display("FAIL rsvret busy3: got %0b want 1", chk_busy1);
    end
    cycle("rsvret_hold");
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    rsv_valid = 1; rsv_addr = 5'd2;
    cycle("rstmid_rsv2");
    rsv_addr = 5'd9;
    cycle("rstmid_rsv9");
    rsv_valid = 0;
    s0_valid = 1; s0_addr = 5'd10; s0_data = 32'hA0A0A0A0;
    cycle("rstmid_s0");
    s0_valid = 0;
    s1_valid = 1; s1_addr = 5'd11; s1_data = 32'hB1B1B1B1;
    #2;
    rst = 1'b0;
    #1;
    clear_inputs();
    check_in_reset("rstmid");
    model_reset();
    release_reset();
    s0_valid = 1; s0_addr = 5'd12; s0_data = 32'h0C0C0C0C;
    s1_valid = 1; s1_addr = 5'd11; s1_data = 32'hB1B1B1B1;
    cycle("rstmid_regrant");
    tests++;
    if (last_g != 0) begin
      fails++; $display("FAIL rstmid first_grant: got s%0d want s0", last_g);
    end
    clear_inputs();
    cycle("rstmid_idle");
  endtask

  task automatic test_random();
    logic [4:0] a;
    for (int n = 0; n < 300; n++) begin
      if (!s0_valid && ($urandom % 2 == 0)) begin
        s0_valid = 1; s0_addr = 5'($urandom % 32); s0_data = $urandom;
      end
      if (!s1_valid && ($urandom % 2 == 0)) begin
        s1_valid = 1; s1_addr = 5'($urandom % 32); s1_data = $urandom;
      end
      rsv_valid = 0;
      if ($urandom % 3 == 0) begin
        a = 5'($urandom % 32);
        if (a != 0 && !exp_busy[a]) begin
          rsv_valid = 1; rsv_addr = a;
        end
      end
      chk_addr1 = 5'($urandom % 32);
      chk_addr2 = (($urandom % 2) == 0) ? exp_waddr : 5'($urandom % 32);
      cycle("random");
      if (last_g == 0) s0_valid = 0;
      if (last_g == 1) s1_valid = 0;
    end
    clear_inputs();
    cycle("random_idle");
  endtask

`ifdef REGFILE_WB_BYPASS_EN
  task automatic test_bypass();
    logic [31:0] d;
    d = $urandom;
    rsv_valid = 1; rsv_addr = 5'd4;
    cycle("bypass_rsv");
    rsv_valid = 0;
    s0_valid = 1; s0_addr = 5'd4; s0_data = d; chk_addr1 = 5'd4;
    cycle("bypass_write");
    s0_valid = 0;
    tests++;
    if (fwd_hit1 !== 1'b1 || fwd_data !== d || chk_busy1 !== 1'b0) begin
      fails++; $display("FAIL bypass hit: got hit=%0b data=%h busy=%0b want 1/%h/0", fwd_hit1, fwd_data, chk_busy1, d);
    end
    cycle("bypass_idle");
    clear_inputs();
  endtask
`endif

  initial begin
    rst = 1'b0;
    clear_inputs();
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    model_reset();
    test_reset();
    test_alternate();
    test_single_write();
    test_busy();
    test_addr0();
    test_rsv_retire();
    test_reset_mid();
`ifdef REGFILE_WB_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
